irda_mir_decoder: RTL and testbench

IRDA_MIR_DECODER -- requirements
Module: irda_mir_decoder

---
 rtl/irda_pkg.sv | 25 ++
 rtl/irda_mir_destuff.sv | 98 +++++++++
 rtl/irda_mir_decoder.sv | 97 +++++++++
 tb/tb_irda_mir_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irda_pkg.sv
// Shared constants and types for the IrDA MIR receive path.
package irda_pkg;

    localparam int PHASE_W      = 2;  // four phases per bit cell
    localparam int PEND_DEPTH   = 6;  // data bits held back until proven not to be flag/abort
    localparam int PEND_CNT_W   = 3;
    localparam int STUFF_THRESH = 5;  // a 0 after this many 1s is a stuffed zero
    localparam int FLAG_CNT     = 6;  // six 1s then a 0 closes a flag
    localparam int ABORT_CNT    = 7;  // seventh consecutive 1 is an abort
    localparam int CNT_W        = 3;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [CNT_W-1:0]   ones_cnt_t;

    localparam phase_t LAST_PHASE = phase_t'((1 << PHASE_W) - 1);

    // What the destuffer does with one raw bit decision.
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_PUSH,
        ACT_FLAG,
        ACT_ABORT
    } destuff_act_e;

endpackage

// File: rtl/irda_mir_destuff.sv
// Zero-bit destuffer with flag/abort detection and a pending FIFO that
// withholds data bits until they can no longer belong to a flag or abort.
module irda_mir_destuff
    import irda_pkg::*;
(
    input  logic clk,
    input  logic wb_rst_i,
    input  logic clear,
    input  logic raw_valid,
    input  logic raw_bit,
    output logic bit_o,
    output logic bit_valid_o,
    output logic flag_o,
    output logic abort_o
);

    ones_cnt_t                ones_cnt;
    ones_cnt_t                ones_cnt_nxt;
    destuff_act_e             act;
    logic [PEND_DEPTH-1:0]    pend_data;
    logic [PEND_CNT_W-1:0]    pend_cnt;
    logic                     pend_full;

    assign pend_full = (pend_cnt == PEND_CNT_W'(PEND_DEPTH));

    // Classify each raw bit against the run of 1s that preceded it.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        act          = ACT_NONE;
        ones_cnt_nxt = ones_cnt;
        if (raw_valid) begin
            if (raw_bit) begin
                if (ones_cnt < ones_cnt_t'(STUFF_THRESH)) begin
                    act          = ACT_PUSH;
                    ones_cnt_nxt = ones_cnt + 1'b1;
                end else if (ones_cnt == ones_cnt_t'(STUFF_THRESH)) begin
                    ones_cnt_nxt = ones_cnt_t'(FLAG_CNT);
                end else if (ones_cnt == ones_cnt_t'(FLAG_CNT)) begin
                    act          = ACT_ABORT;
                    ones_cnt_nxt = ones_cnt_t'(ABORT_CNT);
                end
            end else begin
                if (ones_cnt < ones_cnt_t'(STUFF_THRESH)) begin
                    act = ACT_PUSH;
                end else if (ones_cnt == ones_cnt_t'(FLAG_CNT)) begin
                    act = ACT_FLAG;
                end
                ones_cnt_nxt = '0;
            end
        end
    end

    // Ones counter, FIFO occupancy and registered output strobes.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            ones_cnt    <= '0;
            pend_cnt    <= '0;
            bit_o       <= 1'b0;
            bit_valid_o <= 1'b0;
            flag_o      <= 1'b0;
            abort_o     <= 1'b0;
        end else if (clear) begin
            ones_cnt    <= '0;
            pend_cnt    <= '0;
            bit_o       <= 1'b0;
            bit_valid_o <= 1'b0;
            flag_o      <= 1'b0;
            abort_o     <= 1'b0;
        end else begin
            ones_cnt    <= ones_cnt_nxt;
            bit_valid_o <= 1'b0;
            flag_o      <= (act == ACT_FLAG);
            abort_o     <= (act == ACT_ABORT);
            case (act)
                ACT_PUSH: begin
                    if (pend_full) begin
                        bit_valid_o <= 1'b1;
                        bit_o       <= pend_data[PEND_DEPTH-1];
                    end else begin
                        pend_cnt <= pend_cnt + 1'b1;
                    end
                end
                ACT_FLAG, ACT_ABORT: pend_cnt <= '0;
                default: ;
            endcase
        end
    end

    // Pending data shift register; oldest bit sits at the top once full.
    always_ff @(posedge clk) begin
        // NOTE: the data bits carry no reset; occupancy lives in pend_cnt, so stale contents are never emitted.
        if (act == ACT_PUSH) begin
            pend_data <= {pend_data[PEND_DEPTH-2:0], raw_bit};
        end
    end

endmodule

// File: rtl/irda_mir_decoder.sv
// IrDA MIR receive decoder: synchronizes the raw line, recovers the cell
// phase from received pulses and hands raw bits to the destuffer.
module irda_mir_decoder
    import irda_pkg::*;
(
    input  logic clk,
    input  logic wb_rst_i,
    input  logic mir_rx_i,
    input  logic mir_mode,
    input  logic rx_select,
    input  logic fast_enable,
    output logic mir_rx_bit_o,
    output logic mir_rx_bit_valid_o,
    output logic mir_flag_o,
    output logic mir_abort_o,
    output logic mir_rx_locked_o
);

    logic   rx_meta;
    logic   rx_sync;
    logic   rx_prev;
    logic   pulse_seen;
    logic   locked;
    phase_t phase;
    logic   active;
    logic   en;
    logic   rx_edge;
    logic   decide;
    logic   bit_q;
    logic   valid_q;
    logic   flag_q;
    logic   abort_q;

    // Two-flop synchronizer for the asynchronous receive line, always clocked.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
        end else begin
            rx_meta <= mir_rx_i;
            rx_sync <= rx_meta;
        end
    end

    assign active  = mir_mode & rx_select;
    assign en      = active & fast_enable;
    assign rx_edge = en & rx_sync & ~rx_prev;
    // A pulse edge restarts the cell at its last phase, so its decision waits one phase.
    assign decide  = en & ~rx_edge & locked & (phase == LAST_PHASE);

    // Phase recovery: align to pulse edges, decide one raw bit per cell.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_prev    <= 1'b0;
            phase      <= '0;
            pulse_seen <= 1'b0;
            locked     <= 1'b0;
        end else if (!active) begin
            rx_prev    <= 1'b0;
            phase      <= '0;
            pulse_seen <= 1'b0;
            locked     <= 1'b0;
        end else if (en) begin
            rx_prev <= rx_sync;
            if (rx_edge) begin
                pulse_seen <= 1'b1;
                phase      <= LAST_PHASE;
                locked     <= 1'b1;
            end else begin
                phase <= phase + 1'b1;
                if (decide) begin
                    pulse_seen <= 1'b0;
                end
            end
        end
    end

    // A pulse in the cell is a 0, an empty cell is a 1.
    irda_mir_destuff u_destuff (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .clear       (~active),
        .raw_valid   (decide),
        .raw_bit     (~pulse_seen),
        .bit_o       (bit_q),
        .bit_valid_o (valid_q),
        .flag_o      (flag_q),
        .abort_o     (abort_q)
    );

    assign mir_rx_bit_o       = bit_q & active;
    assign mir_rx_bit_valid_o = valid_q & active;
    assign mir_flag_o         = flag_q & active;
    assign mir_abort_o        = abort_q & active;
    assign mir_rx_locked_o    = locked;

endmodule

// File: tb/tb_irda_mir_decoder.sv
// Directed bench for irda_mir_decoder with a bit-level MIR encoder model.
module tb_irda_mir_decoder;

    logic clk = 1'b0;
    logic wb_rst_i;
    logic mir_rx_i;
    logic mir_mode;
    logic rx_select;
    logic fast_enable;
    logic mir_rx_bit_o;
    logic mir_rx_bit_valid_o;
    logic mir_flag_o;
    logic mir_abort_o;
    logic mir_rx_locked_o;

    always #5 clk = ~clk;

    irda_mir_decoder dut (
        .clk                (clk),
        .wb_rst_i           (wb_rst_i),
        .mir_rx_i           (mir_rx_i),
        .mir_mode           (mir_mode),
        .rx_select          (rx_select),
        .fast_enable        (fast_enable),
        .mir_rx_bit_o       (mir_rx_bit_o),
        .mir_rx_bit_valid_o (mir_rx_bit_valid_o),
        .mir_flag_o         (mir_flag_o),
        .mir_abort_o        (mir_abort_o),
        .mir_rx_locked_o    (mir_rx_locked_o)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   valid_cnt = 0;
    int   flag_cnt = 0;
    int   abort_cnt = 0;
    int   valid_at_abort = 0;
    logic both_seen = 1'b0;
    logic got_bits[$];
    int   tx_ones = 0;

    typedef struct {
        int v;
        int f;
        int a;
    } snap_t;

    // Strobe monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (mir_rx_bit_valid_o) begin
            got_bits.push_back(mir_rx_bit_o);
            valid_cnt++;
        end
        if (mir_flag_o) flag_cnt++;
        if (mir_abort_o) begin
            abort_cnt++;
            valid_at_abort = valid_cnt;
        end
        if (mir_flag_o && mir_abort_o) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.v = valid_cnt;
        s.f = flag_cnt;
        s.a = abort_cnt;
        return s;
    endfunction

    function automatic logic [15:0] grab16(input int base);
        logic [15:0] r;
        r = 'x;
        for (int i = 0; i < 16; i++) begin
            if (base + i < got_bits.size()) r[i] = got_bits[base + i];
        end
        return r;
    endfunction

    // One phase period: line value for the period, then a one-clk fast_enable.
    task automatic tick(input logic rx);
        @(negedge clk);
        mir_rx_i = rx;
        repeat (2) @(negedge clk);
        fast_enable = 1'b1;
        @(negedge clk);
        fast_enable = 1'b0;
    endtask

    // Encoder: a 0 is a pulse in phase 2, a 1 is an empty cell.
    task automatic send_cell(input logic b);
        for (int p = 0; p < 4; p++) tick((b == 1'b0) && (p == 2));
    endtask

    task automatic send_data_bit(input logic b);
        send_cell(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 5) begin
                send_cell(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int skew_at);
        for (int i = 0; i < 8; i++) begin
            if (i == skew_at) tick(1'b0);
            send_data_bit(b[i]);
        end
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_cell(f[i]);
        tx_ones = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wb_rst_i = 1'b1;
        mir_rx_i = 1'b0;
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b0;
        tx_ones  = 0;
    endtask

    initial begin
        snap_t       s;
        snap_t       s2;
        logic [15:0] g;

        wb_rst_i    = 1'b1;
        mir_rx_i    = 1'b0;
        mir_mode    = 1'b1;
        rx_select   = 1'b1;
        fast_enable = 1'b0;

        // Reset: all outputs low during and right after reset.
        repeat (3) @(negedge clk);
        check("rst_during", 32'({mir_rx_bit_o, mir_rx_bit_valid_o, mir_flag_o, mir_abort_o, mir_rx_locked_o}), 32'h0);
        wb_rst_i = 1'b0;
        @(negedge clk);
        check("rst_after", 32'({mir_rx_bit_o, mir_rx_bit_valid_o, mir_flag_o, mir_abort_o, mir_rx_locked_o}), 32'h0);

        // Idle line for 40 enable cycles: no lock, no strobes.
        s = snap();
        repeat (40) tick(1'b0);
        check("idle_locked", 32'(mir_rx_locked_o), 32'h0);
        check("idle_valid", 32'(valid_cnt - s.v), 32'd0);
        check("idle_flag", 32'(flag_cnt - s.f), 32'd0);
        check("idle_abort", 32'(abort_cnt - s.a), 32'd0);

        // Frame A5 3C between flags.
        s = snap();
        send_flag();
        send_byte(8'hA5, -1);
        send_byte(8'h3C, -1);
        send_flag();
        repeat (2) @(negedge clk);
        check("frame_valid", 32'(valid_cnt - s.v), 32'd16);
        check("frame_bits", 32'(grab16(s.v)), 32'h3CA5);
        check("frame_flags", 32'(flag_cnt - s.f), 32'd2);
        check("frame_abort", 32'(abort_cnt - s.a), 32'd0);
        check("frame_locked", 32'(mir_rx_locked_o), 32'h1);

        // Payload FF 1F: stuffed zeros must be dropped.
        do_reset();
        s = snap();
        send_flag();
        send_byte(8'hFF, -1);
        send_byte(8'h1F, -1);
        send_flag();
        repeat (2) @(negedge clk);
        check("stuff_valid", 32'(valid_cnt - s.v), 32'd16);
        check("stuff_bits", 32'(grab16(s.v)), 32'h1FFF);
        check("stuff_flags", 32'(flag_cnt - s.f), 32'd2);
        check("stuff_abort", 32'(abort_cnt - s.a), 32'd0);

        // Flag, data 0 1 0, then fifteen 1s: one abort, counter saturates.
        do_reset();
        s = snap();
        send_flag();
        send_data_bit(1'b0);
        send_data_bit(1'b1);
        send_data_bit(1'b0);
        repeat (15) send_cell(1'b1);
        repeat (2) @(negedge clk);
        g = grab16(s.v);
        check("abort_count", 32'(abort_cnt - s.a), 32'd1);
        check("abort_valid", 32'(valid_cnt - s.v), 32'd2);
        check("abort_bits", 32'(g[1:0]), 32'h2);
        check("abort_no_valid_after", 32'(valid_cnt - valid_at_abort), 32'd0);
        check("abort_flags", 32'(flag_cnt - s.f), 32'd1);

        // Encoder skewed by one enable cycle mid-byte; realigns on the next pulse.
        do_reset();
        s = snap();
        send_flag();
        send_byte(8'hA5, 2);
        send_byte(8'h3C, -1);
        send_flag();
        repeat (2) @(negedge clk);
        check("skew_valid", 32'(valid_cnt - s.v), 32'd16);
        check("skew_bits", 32'(grab16(s.v)), 32'h3CA5);
        check("skew_flags", 32'(flag_cnt - s.f), 32'd2);

        // rx_select dropped mid-frame: pending bits discarded, lock lost.
        do_reset();
        s = snap();
        send_flag();
        for (int i = 0; i < 4; i++) send_data_bit(1'(8'hA5 >> i));
        @(negedge clk);
        rx_select = 1'b0;
        repeat (8) tick(1'b0);
        check("desel_locked", 32'(mir_rx_locked_o), 32'h0);
        @(negedge clk);
        rx_select = 1'b1;
        repeat (4) tick(1'b0);
        check("resel_locked", 32'(mir_rx_locked_o), 32'h0);
        s2 = snap();
        check("desel_discard", 32'(s2.v - s.v), 32'd0);
        tx_ones = 0;
        send_flag();
        send_byte(8'hA5, -1);
        send_byte(8'h3C, -1);
        send_flag();
        repeat (2) @(negedge clk);
        check("resel_valid", 32'(valid_cnt - s2.v), 32'd16);
        check("resel_bits", 32'(grab16(s2.v)), 32'h3CA5);
        check("resel_flags", 32'(flag_cnt - s2.f), 32'd2);

        check("flag_abort_overlap", 32'(both_seen), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
